base64_to_ascii: RTL and testbench
==================================

BASE64_TO_ASCII -- requirements
Module: base64_to_ascii

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_sym  input  6  base64 index (0..63), MSB-first bit stream.
REQ-005 in_valid  input  1  in_sym/in_last are valid this cycle.
REQ-006 in_last  input  1  marks the final symbol of a message; qualified by in_valid.
REQ-007 in_ready  output  1  block can accept a symbol this cycle.
REQ-008 out_ascii  output  7  decoded 7-bit ASCII character.
REQ-009 out_valid  output  1  out_ascii/out_last are valid.
REQ-010 out_last  output  1  marks the final character of a message.
REQ-011 out_ready  input  1  downstream accepts the character this cycle.
REQ-012 drop_err  output  1  one-cycle pulse: message ended with fewer than 7 pending bits, so no character could be formed.

Function
REQ-013 Symbol accept SHALL occur on a rising edge when in_valid && in_ready; character transfer SHALL occur when out_valid && out_ready.
REQ-014 The block SHALL keep a bit accumulator of at least 12 bits and a pending-bit counter cnt in the range 0..12; the oldest bit SHALL be the most significant.
REQ-015 in_ready SHALL equal (cnt <= 6) && !flush; it is a function of registered state only, with no combinational path from inputs.
REQ-016 On accept, the block SHALL append the 6 bits of in_sym below the pending bits and set cnt to cnt+6.
REQ-017 Extract SHALL occur when cnt >= 7 && (!out_valid || out_ready).
REQ-018 On extract, the block SHALL load the 7 oldest pending bits into out_ascii, set out_valid to 1, and set cnt to cnt-7.
REQ-019 Accept and extract are mutually exclusive by construction (cnt <= 6 vs cnt >= 7); the design SHALL NOT rely on simultaneous occurrence.
REQ-020 Latency: an accept that makes cnt >= 7 at edge N SHALL produce out_valid=1 after edge N+1, provided the output register is free.
REQ-021 out_valid SHALL clear after a transfer when no extract occurs in the same cycle.
REQ-022 out_ascii and out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 Seven symbols (42 bits) SHALL yield exactly six characters and leave cnt=0.
REQ-024 Accepting a symbol with in_last=1 SHALL set flush=1, which forces in_ready=0.
REQ-025 While flush=1, extract SHALL continue as normal; the extract that leaves cnt < 7 SHALL set out_last=1, set cnt=0 (discarding the residual pad bits) and clear flush.
REQ-026 If, at the in_last accept, cnt+6 < 7, the block SHALL emit no character, pulse drop_err for exactly one cycle, set cnt=0 and leave flush=0.
REQ-027 out_last SHALL be 0 for every character that is not the last character of a message.
REQ-028 Character value 0x00 SHALL be emitted like any other value; it is not a terminator.
REQ-029 in_sym SHALL be ignored when no accept occurs, and in_last SHALL be ignored without in_valid.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set cnt=0, flush=0, accumulator=0, out_valid=0, out_last=0, out_ascii=0 and drop_err=0.
REQ-031 In the cycle after reset, in_ready SHALL be 1.
REQ-032 Reset mid-message SHALL discard all pending bits and any held character, with no out_valid pulse afterwards.

Verification
REQ-033 Symbols 0x20, 0x30 (in_last on second), out_ready=1 -> one character 0x41 ("A") with out_last=1; residual bits discarded; in_ready returns to 1.
REQ-034 Seven symbols 0x3F, the last with in_last=1 -> six characters 0x7F, only the sixth with out_last=1; cnt=0 at end.
REQ-035 Single symbol 0x15 with in_last=1 -> no out_valid; drop_err high exactly one cycle; the next message decodes normally.
REQ-036 out_ready held 0 for 5 cycles with a character pending -> out_ascii stable, in_ready=0 once cnt >= 7, no data loss when out_ready rises.
REQ-037 Assert rst after 3 of 7 symbols, then send 0x20, 0x30 with in_last -> only 0x41 emitted, out_last=1.
REQ-038 Random symbol stream with random out_ready -> output matches a reference MSB-first 6-to-7-bit repacker; in_ready/out_valid handshake rules are never violated.

Source files
------------

// File: rtl/base64_to_ascii.sv
// -----------------------------------------------------------------------------
// base64_to_ascii
//   Repacks a stream of 6-bit base64 symbol indices into 7-bit ASCII
//   characters, MSB first. Pending bits sit right-aligned in a 12-bit
//   accumulator. The oldest pending bit is the most significant valid bit.
//
//   On the last symbol of a message the block flushes: it emits the final
//   whole character flagged with out_last and throws away the residual pad
//   bits. A message too short to form any character ends with a one-cycle
//   drop_err pulse instead.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_sym     in   6  base64 index, MSB-first bits
//   in_valid   in   1  in_sym / in_last valid
//   in_last    in   1  final symbol of the message (qualified by in_valid)
//   in_ready   out  1  symbol accepted this cycle when in_valid is high
//   out_ascii  out  7  decoded character
//   out_valid  out  1  out_ascii / out_last valid
//   out_last   out  1  final character of the message
//   out_ready  in   1  downstream takes the character this cycle
//   drop_err   out  1  one-cycle pulse: message ended without a character
// -----------------------------------------------------------------------------
module base64_to_ascii (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_sym,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [6:0] out_ascii,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       drop_err
);

  logic [11:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_flush;
  logic [6:0]  r_out_ascii;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_drop_err;

  logic        w_accept;
  logic        w_extract;
  logic [6:0]  w_char;

  // in_ready depends on registered state only.
  assign in_ready  = (r_cnt <= 4'd6) && !r_flush;
  assign w_accept  = in_valid && in_ready;
  // Accept needs cnt <= 6 and extract needs cnt >= 7, so they never coincide.
  assign w_extract = (r_cnt >= 4'd7) && (!r_out_valid || out_ready);

  // Select the 7 oldest pending bits; the value is only used when cnt >= 7.
  always_comb begin
    w_char = 7'(r_acc >> (r_cnt - 4'd7));
  end

  // Accumulator, pending-bit count, flush flag and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= 12'd0;
      r_cnt      <= 4'd0;
      r_flush    <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= 1'b0;
      if (w_accept) begin
        // With cnt <= 6, cnt+6 < 7 only when nothing is pending.
        if (in_last && (r_cnt == 4'd0)) begin
          r_acc      <= 12'd0;
          r_cnt      <= 4'd0;
          r_flush    <= 1'b0;
          r_drop_err <= 1'b1;
        end else begin
          r_acc   <= {r_acc[5:0], in_sym};
          r_cnt   <= r_cnt + 4'd6;
          r_flush <= in_last;
        end
      end else if (w_extract) begin
        // While flushing cnt <= 12, so one extract always leaves < 7 bits.
        if (r_flush) begin
          r_cnt   <= 4'd0;
          r_flush <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd7;
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Output character register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_ascii <= 7'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_extract) begin
      r_out_ascii <= w_char;
      r_out_valid <= 1'b1;
      r_out_last  <= r_flush;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_ascii = r_out_ascii;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_base64_to_ascii.sv
module tb_base64_to_ascii;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in_sym = 6'h3F;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b1;
  logic       in_ready;
  logic [6:0] out_ascii;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       drop_err;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;

  logic [6:0] got_chr[$];
  logic       got_last[$];
  logic       rnd_ready = 1'b0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_rst = 1'b1;
  logic       prev_l = 1'b0;
  logic [6:0] prev_a = 7'd0;

  base64_to_ascii dut (
    .clk(clk), .rst(rst),
    .in_sym(in_sym), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_ascii(out_ascii), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Output monitor on the falling edge: collects transfers, counts drop
  // pulses and checks that a stalled character holds steady.
  always @(negedge clk) begin
    if (prev_v && !prev_r && !prev_rst) begin
      checks++;
      if (!out_valid || out_ascii !== prev_a || out_last !== prev_l) begin
        errors++;
        $display("FAIL hold: valid=%b ascii=%h last=%b required valid=1 ascii=%h last=%b",
                 out_valid, out_ascii, out_last, prev_a, prev_l);
      end
    end
    if (out_valid && out_ready) begin
      got_chr.push_back(out_ascii);
      got_last.push_back(out_last);
    end
    if (drop_err) drop_cnt++;
    prev_v   = out_valid;
    prev_r   = out_ready;
    prev_rst = rst;
    prev_a   = out_ascii;
    prev_l   = out_last;
  end

  // Random downstream backpressure for the stream scenario.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Present one symbol and hold it until accepted (bounded wait).
  task automatic send_sym(input logic [5:0] s, input logic l);
    int n;
    n = 0;
    in_sym = s;
    in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 300 cycles", in_ready);
    end
    tick(1);
    in_valid = 1'b0;
    in_sym = 6'h2A;
    in_last = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b exp 0", out_last); end
    if (out_ascii !== 7'h00) begin errors++; $display("FAIL rst_out_ascii: got %h exp 00", out_ascii); end
    if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop_err: got %b exp 0", drop_err); end
  endtask

  task automatic test_single_char;
    int d0;
    d0 = drop_cnt;
    got_chr.delete(); got_last.delete();
    out_ready = 1'b1;
    send_sym(6'h20, 1'b0);
    send_sym(6'h30, 1'b1);
    tick(4);
    checks += 3;
    if (got_chr.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d exp 1", got_chr.size());
    end else begin
      checks += 2;
      if (got_chr[0] !== 7'h41) begin errors++; $display("FAIL single_char: got %h exp 41", got_chr[0]); end
      if (got_last[0] !== 1'b1) begin errors++; $display("FAIL single_last: got %b exp 1", got_last[0]); end
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b exp 1", in_ready); end
    if (drop_cnt != d0) begin errors++; $display("FAIL single_drop: got %0d exp 0", drop_cnt - d0); end
  endtask

  task automatic test_seven;
    got_chr.delete(); got_last.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_sym(6'h3F, (i == 6) ? 1'b1 : 1'b0);
    tick(5);
    checks += 2;
    if (got_chr.size() != 6) begin
      errors++; $display("FAIL seven_count: got %0d exp 6", got_chr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks += 2;
        if (got_chr[i] !== 7'h7F) begin errors++; $display("FAIL seven_char[%0d]: got %h exp 7f", i, got_chr[i]); end
        if (got_last[i] !== (i == 5)) begin errors++; $display("FAIL seven_last[%0d]: got %b exp %b", i, got_last[i], (i == 5)); end
      end
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL seven_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_drop;
    int d0;
    d0 = drop_cnt;
    got_chr.delete(); got_last.delete();
    out_ready = 1'b1;
    send_sym(6'h15, 1'b1);
    tick(4);
    checks += 3;
    if (got_chr.size() != 0) begin errors++; $display("FAIL drop_no_char: got %0d chars exp 0", got_chr.size()); end
    if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop_pulse: got %0d cycles exp 1", drop_cnt - d0); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready: got %b exp 1", in_ready); end
    send_sym(6'h20, 1'b0);
    send_sym(6'h30, 1'b1);
    tick(4);
    checks++;
    if (got_chr.size() != 1) begin
      errors++; $display("FAIL drop_next_count: got %0d exp 1", got_chr.size());
    end else begin
      checks += 2;
      if (got_chr[0] !== 7'h41) begin errors++; $display("FAIL drop_next_char: got %h exp 41", got_chr[0]); end
      if (got_last[0] !== 1'b1) begin errors++; $display("FAIL drop_next_last: got %b exp 1", got_last[0]); end
    end
  endtask

  task automatic test_backpressure;
    logic [6:0] exp_c[3];
    logic       exp_l[3];
    exp_c = '{7'h21, 7'h04, 7'h2F};
    exp_l = '{1'b0, 1'b0, 1'b1};
    got_chr.delete(); got_last.delete();
    out_ready = 1'b0;
    send_sym(6'h10, 1'b0);
    send_sym(6'h21, 1'b0);
    send_sym(6'h05, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, out_valid); end
      if (out_ascii !== 7'h21) begin errors++; $display("FAIL bp_ascii[%0d]: got %h exp 21", i, out_ascii); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", i, in_ready); end
      tick(1);
    end
    out_ready = 1'b1;
    send_sym(6'h3C, 1'b1);
    tick(5);
    checks++;
    if (got_chr.size() != 3) begin
      errors++; $display("FAIL bp_count: got %0d exp 3", got_chr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (got_chr[i] !== exp_c[i]) begin errors++; $display("FAIL bp_char[%0d]: got %h exp %h", i, got_chr[i], exp_c[i]); end
        if (got_last[i] !== exp_l[i]) begin errors++; $display("FAIL bp_last[%0d]: got %b exp %b", i, got_last[i], exp_l[i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_sym(6'h3F, 1'b0);
    send_sym(6'h3F, 1'b0);
    send_sym(6'h3F, 1'b0);
    tick(1);
    do_reset();
    got_chr.delete(); got_last.delete();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b exp 1", in_ready); end
    out_ready = 1'b1;
    tick(3);
    send_sym(6'h20, 1'b0);
    send_sym(6'h30, 1'b1);
    tick(4);
    checks++;
    if (got_chr.size() != 1) begin
      errors++; $display("FAIL mid_count: got %0d exp 1", got_chr.size());
    end else begin
      checks += 2;
      if (got_chr[0] !== 7'h41) begin errors++; $display("FAIL mid_char: got %h exp 41", got_chr[0]); end
      if (got_last[0] !== 1'b1) begin errors++; $display("FAIL mid_last: got %b exp 1", got_last[0]); end
    end
  endtask

  task automatic test_random_stream;
    logic [6:0] exp_c[$];
    logic       exp_l[$];
    bit         bq[$];
    logic [5:0] s;
    logic [6:0] v;
    int k, n, d0, exp_drops, w;
    logic drop;
    d0 = drop_cnt;
    exp_drops = 0;
    got_chr.delete(); got_last.delete();
    rnd_ready = 1'b1;
    for (int m = 0; m < 8; m++) begin
      k = (m == 0) ? 8 : ((m == 1) ? 1 : int'($urandom_range(2, 9)));
      bq.delete();
      for (int j = 0; j < k; j++) begin
        s = 6'($urandom_range(0, 63));
        for (int b = 5; b >= 0; b--) bq.push_back(s[b]);
        send_sym(s, (j == k - 1) ? 1'b1 : 1'b0);
      end
      drop = ((6 * (k - 1)) % 7) == 0;
      if (drop) exp_drops++;
      n = bq.size() / 7;
      for (int c = 0; c < n; c++) begin
        v = 7'd0;
        for (int b = 0; b < 7; b++) v = {v[5:0], 1'(bq[c * 7 + b])};
        exp_c.push_back(v);
        exp_l.push_back((c == n - 1) && !drop);
      end
    end
    w = 0;
    while (got_chr.size() < exp_c.size() && w < 2000) begin
      tick(1);
      w++;
    end
    rnd_ready = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(4);
    checks += 2;
    if (got_chr.size() != exp_c.size()) begin
      errors++; $display("FAIL rand_count: got %0d exp %0d", got_chr.size(), exp_c.size());
    end
    if (drop_cnt - d0 != exp_drops) begin
      errors++; $display("FAIL rand_drops: got %0d exp %0d", drop_cnt - d0, exp_drops);
    end
    for (int i = 0; i < exp_c.size() && i < got_chr.size(); i++) begin
      checks += 2;
      if (got_chr[i] !== exp_c[i]) begin errors++; $display("FAIL rand_char[%0d]: got %h exp %h", i, got_chr[i], exp_c[i]); end
      if (got_last[i] !== exp_l[i]) begin errors++; $display("FAIL rand_last[%0d]: got %b exp %b", i, got_last[i], exp_l[i]); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_char();
    test_seven();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
